// File: rtl/demux4_deser_pkg.sv
// demux_pkg -- shared constants and FSM state type for the 4-lane deserializer.
//   LANES  : number of output lanes per frame
//   SLOT_W : width of the lane slot counter
//   state_t: COLLECT (gathering lanes) / FULL (frame presented downstream)
package demux_pkg;

    localparam int LANES  = 4;
    localparam int SLOT_W = 2;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

endpackage

// File: rtl/demux4_deser_lane_reg.sv
// demux_lane_reg -- one DW-bit lane storage register.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (clears q)
//   en       : write enable
//   d        : data written when en is high
//   q        : stored lane word
module demux_lane_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/demux4_deser.sv
// demux4_deser -- serial-to-parallel deserializer: collects 4 consecutive
// accepted words into lanes 0..3 and presents them as one frame with a
// valid/ready handshake.
// Optional build macro: DEMUX_SEL_CHECK_EN enables lane-tag checking
// (mismatching words are dropped, err is set sticky, slot restarts at 0).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : serial word present
//   in_ready   : word accepted this cycle (!out_valid || out_ready)
//   in_data    : serial word
//   in_sel     : sender lane tag (checked only with DEMUX_SEL_CHECK_EN)
//   out_valid  : all 4 lanes filled and presented
//   out_ready  : sink takes the frame
//   out_data   : lane k on bits [k*DW +: DW]
//   frame_cnt  : count of completed output handshakes (wraps)
//   err        : sticky lane-tag mismatch flag
module demux4_deser
    import demux_pkg::*;
#(
    parameter int DW   = 8,
    parameter int CNTW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    input  logic [1:0]        in_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*DW-1:0]   out_data,
    output logic [CNTW-1:0]   frame_cnt,
    output logic              err
);

    state_t              state, state_nx;
    logic [SLOT_W-1:0]   slot, slot_nx;
    logic                accept;
    logic                handshake;
    logic                mismatch;
    logic                wr;
    logic                last;
    logic [LANES-1:0]    lane_we;
    logic [DW-1:0]       lane_q [LANES];

    assign out_valid = (state == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

`ifdef DEMUX_SEL_CHECK_EN
    assign mismatch = accept && (in_sel != slot);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (mismatch) begin
            err <= 1'b1;
        end
    end
`else
    logic sel_unused;
    assign sel_unused = ^in_sel;
    assign mismatch   = 1'b0;
    assign err        = 1'b0;
`endif

    assign wr   = accept && !mismatch;
    assign last = wr && (slot == SLOT_W'(LANES - 1));

    // Next slot and state. A slot-3 write during a handshake keeps FULL,
    // since the freshly completed frame must be presented next.
    always_comb begin
        slot_nx  = slot;
        state_nx = state;
        if (mismatch) begin
            slot_nx = '0;
        end else if (wr) begin
            slot_nx = slot + 1'b1;
        end
        case (state)
            COLLECT: if (last) state_nx = FULL;
            FULL:    if (handshake && !last) state_nx = COLLECT;
            default: state_nx = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            slot      <= '0;
            frame_cnt <= '0;
        end else begin
            state <= state_nx;
            slot  <= slot_nx;
            if (handshake) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_we[k] = wr && (slot == SLOT_W'(k));

        demux_lane_reg #(
            .DW (DW)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .en  (lane_we[k]),
            .d   (in_data),
            .q   (lane_q[k])
        );

        assign out_data[k*DW +: DW] = lane_q[k];
    end

endmodule

// File: doc/demux4_deser.md
DEMUX4_DESER -- requirements
Module: demux4_deser

Interface
REQ-001 SHALL have parameter DW, default 8, meaning bit width of one lane word.
REQ-002 SHALL have parameter CNTW, default 8, meaning width of the frame counter.
REQ-003 SHALL have port clk  input  1  single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous reset, active-high.
REQ-005 SHALL have port in_valid  input  1  a serial input word is present.
REQ-006 SHALL have port in_ready  output  1  the block accepts a word this cycle.
REQ-007 SHALL have port in_data  input  DW  the serial word.
REQ-008 SHALL have port in_sel  input  2  the sender's lane tag for in_data.
REQ-009 SHALL have port out_valid  output  1  all 4 lanes are filled and presented.
REQ-010 SHALL have port out_ready  input  1  the downstream sink takes the frame.
REQ-011 SHALL have port out_data  output  4*DW  lane k on bits [k*DW +: DW].
REQ-012 SHALL have port frame_cnt  output  CNTW  count of completed output handshakes.
REQ-013 SHALL have port err  output  1  sticky lane-tag mismatch flag.

Function
REQ-014 SHALL accept a word when in_valid && in_ready; in_ready = !out_valid || out_ready, combinationally.
REQ-015 SHALL hold a 2-bit slot counter; an accepted word SHALL be written to lane[slot] and slot SHALL increment, wrapping 3->0.
REQ-016 SHALL operate as a 2-state FSM: COLLECT (out_valid=0) and FULL (out_valid=1).
REQ-017 SHALL move COLLECT->FULL on the edge that accepts the slot-3 word, so out_valid rises 1 cycle after the 4th accept.
REQ-018 SHALL move FULL->COLLECT on out_valid && out_ready, unless a slot-3 word is accepted in the same cycle, in which case it SHALL stay in FULL.
REQ-019 SHALL keep out_data stable while out_valid && !out_ready.
REQ-020 SHALL let a lane write and an output handshake occur in the same cycle, because the sink samples the old value before the edge.
REQ-021 SHALL increment frame_cnt by 1 per output handshake, wrapping 2^CNTW-1 -> 0.
REQ-022 SHALL accept words one per cycle at full throughput while out_ready is held high (4 words per frame, no bubbles).

Reset
REQ-023 SHALL, on rst assertion, immediately force slot=0, state=COLLECT, out_valid=0, out_data=0, frame_cnt=0 and err=0.
REQ-024 SHALL discard any partially collected frame if rst asserts mid-frame; after release, collection SHALL restart at lane 0.
REQ-025 SHALL assert in_ready from the first clock edge after rst deasserts.

Configuration
REQ-026 SHALL compile lane-tag checking when DEMUX_SEL_CHECK_EN is defined: an accepted word with in_sel != slot SHALL be dropped (no lane write), SHALL set err, and SHALL reset slot to 0; err SHALL clear only on rst.
REQ-027 SHALL, when DEMUX_SEL_CHECK_EN is undefined, ignore in_sel, tie err to 0 and write every accepted word.

Structure
REQ-028 SHALL take LANES=4, SLOT_W=2 and the FSM state enum (COLLECT, FULL) from shared package demux_pkg.
REQ-029 SHALL implement the per-lane storage as sub-module demux_lane_reg (DW-bit register with write enable and async active-high reset), instantiated 4 times.

Verification
REQ-030 SHALL cover: out_ready=1, words 0x11,0x22,0x33,0x44 with sel 0..3 on consecutive cycles -> out_valid 1 cycle after the 4th word, out_data=0x44332211, frame_cnt=1.
REQ-031 SHALL cover: out_ready=0 after a frame -> in_ready=0 and out_data held for 10 cycles; then out_ready=1 plus a new word 0xAA -> handshake and lane0=0xAA accepted in the same cycle.
REQ-032 SHALL cover: rst pulse after 2 words -> all outputs 0; next words 0x55..0x88 -> out_data=0x88776655.
REQ-033 SHALL cover (DEMUX_SEL_CHECK_EN): words tagged sel 0,1,3 -> err=1 and slot=0 after the 3rd word; a following sel-0..3 frame completes normally with err still 1.
REQ-034 SHALL cover: 256 back-to-back frames with CNTW=8 -> frame_cnt wraps to 0 and no bubble occurs in in_ready.
